// File: rtl/dmem_port_ctrl_pkg.sv
// Shared types, defaults and the address range helper for the data-RAM port controller.
package dmem_port_ctrl_pkg;

  localparam int MC_MEM_BYTES  = 1024;
  localparam int MC_AW         = 10;
  localparam int MC_TIMEOUT    = 16;
  localparam int MC_STARVE_MAX = 4;

  // Access sequencer states.
  typedef enum logic [2:0] {
    MC_IDLE = 3'd0,
    MC_REQ  = 3'd1,
    MC_WAIT = 3'd2,
    MC_ERR  = 3'd3,
    MC_DONE = 3'd4
  } mc_state_e;

  // Requester identity.
  typedef enum logic {
    MC_PORT_IF = 1'b0,
    MC_PORT_DM = 1'b1
  } mc_port_e;

  // An 8-byte access is legal when its last byte (addr+7, computed in 65 bits so
  // a wrap past 2^64 shows up as a huge value) still lies inside the RAM.
  function automatic logic mc_addr_ok(input logic [63:0] addr, input int mem_bytes);
    logic [64:0] last_byte;
    last_byte = {1'b0, addr} + 65'd7;
    return last_byte < 65'(mem_bytes);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter (data port first) with a starvation counter that
// forces a fetch grant after STARVE_MAX consecutive data wins over a waiting fetch.
module mem_port_arbiter
  import dmem_port_ctrl_pkg::*;
#(
  parameter int STARVE_MAX = MC_STARVE_MAX
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     arb_en_i,
  input  logic     if_req_i,
  input  logic     dm_req_i,
  output logic     gnt_valid_o,
  output mc_port_e gnt_port_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          force_if;

  // Grant decision and starvation counter update.
  always_comb begin
    force_if     = if_req_i && (starve_cnt_q == SW'(STARVE_MAX));
    gnt_valid_o  = arb_en_i && (if_req_i || dm_req_i);
    gnt_port_o   = (force_if || !dm_req_i) ? MC_PORT_IF : MC_PORT_DM;
    starve_cnt_d = starve_cnt_q;
    if (gnt_valid_o) begin
      if (gnt_port_o == MC_PORT_IF) begin
        starve_cnt_d = '0;
      end else if (if_req_i) begin
        starve_cnt_d = starve_cnt_q + SW'(1);
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/dmem_port_ctrl.sv
// Data-RAM port sequencer: arbitrates fetch vs memory stage, range-checks the
// address, runs the req/gnt/rvalid handshake with a timeout, and returns one ack.
module dmem_port_ctrl
  import dmem_port_ctrl_pkg::*;
#(
  parameter int MEM_BYTES  = MC_MEM_BYTES,
  parameter int AW         = MC_AW,
  parameter int TIMEOUT    = MC_TIMEOUT,
  parameter int STARVE_MAX = MC_STARVE_MAX
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [63:0]   if_addr_i,
  output logic          if_ack_o,
  output logic [63:0]   if_rdata_o,
  output logic          if_err_o,
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [63:0]   dm_addr_i,
  input  logic [63:0]   dm_wdata_i,
  output logic          dm_ack_o,
  output logic [63:0]   dm_rdata_o,
  output logic          dm_err_o,
  output logic          ram_req_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [63:0]   ram_wdata_o,
  input  logic          ram_gnt_i,
  input  logic          ram_rvalid_i,
  input  logic [63:0]   ram_rdata_i,
  output logic          busy_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  mc_state_e     state_q, state_d;
  mc_port_e      port_q, port_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          stale_q, stale_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  logic          gnt_valid;
  mc_port_e      gnt_port;
  logic [63:0]   sel_addr;
  logic          tmo_hit;
  logic          ack;

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .arb_en_i   (state_q == MC_IDLE),
    .if_req_i   (if_req_i),
    .dm_req_i   (dm_req_i),
    .gnt_valid_o(gnt_valid),
    .gnt_port_o (gnt_port)
  );

  assign sel_addr = (gnt_port == MC_PORT_DM) ? dm_addr_i : if_addr_i;
  assign tmo_hit  = (tmo_cnt_q == TW'(TIMEOUT - 1));

  // Next-state logic: grant latching, handshake progress, timeout and stale tracking.
  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    stale_d   = stale_q;
    tmo_cnt_d = tmo_cnt_q;
    // Leftover data from an aborted read is swallowed whatever state we are in.
    if (stale_q && ram_rvalid_i) begin
      stale_d = 1'b0;
    end
    unique case (state_q)
      MC_IDLE: begin
        if (gnt_valid) begin
          port_d    = gnt_port;
          we_d      = (gnt_port == MC_PORT_DM) && dm_we_i;
          wdata_d   = (gnt_port == MC_PORT_DM) ? dm_wdata_i : '0;
          addr_d    = sel_addr[AW-1:0];
          rdata_d   = '0;
          tmo_cnt_d = '0;
          err_d     = !mc_addr_ok(sel_addr, MEM_BYTES);
          state_d   = mc_addr_ok(sel_addr, MEM_BYTES) ? MC_REQ : MC_ERR;
        end
      end
      MC_REQ: begin
        if (ram_gnt_i && we_q) begin
          state_d = MC_DONE;
        end else if (tmo_hit) begin
          // A read accepted on the very last cycle cannot complete in time;
          // its data will still arrive later and must be dropped.
          err_d   = 1'b1;
          state_d = MC_DONE;
          if (ram_gnt_i) begin
            stale_d = 1'b1;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
          if (ram_gnt_i) begin
            state_d = MC_WAIT;
          end
        end
      end
      MC_WAIT: begin
        if (ram_rvalid_i && !stale_q) begin
          rdata_d = ram_rdata_i;
          state_d = MC_DONE;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          stale_d = 1'b1;
          state_d = MC_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      MC_ERR:  state_d = MC_DONE;
      MC_DONE: state_d = MC_IDLE;
      default: state_d = MC_IDLE;
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= MC_IDLE;
      port_q    <= MC_PORT_IF;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      stale_q   <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      stale_q   <= stale_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign ack        = (state_q == MC_DONE);
  assign if_ack_o   = ack && (port_q == MC_PORT_IF);
  assign dm_ack_o   = ack && (port_q == MC_PORT_DM);
  assign if_rdata_o = if_ack_o ? rdata_q : '0;
  assign dm_rdata_o = dm_ack_o ? rdata_q : '0;
  assign if_err_o   = if_ack_o && err_q;
  assign dm_err_o   = dm_ack_o && err_q;

  assign ram_req_o   = (state_q == MC_REQ);
  assign ram_we_o    = ram_req_o && we_q;
  assign ram_addr_o  = ram_req_o ? addr_q : '0;
  assign ram_wdata_o = ram_req_o ? wdata_q : '0;

  assign busy_o = (state_q != MC_IDLE);

endmodule
